// File: rtl/interp_bilinear_hs.sv
// Bilinear / nearest-neighbour pixel interpolator over four corner pixels.
// Latency: 4 register stages, one beat per cycle, bubbles are not compressed.
// Backpressure: whole pipe holds when out_valid & !out_ready; in_ready = advance.
module interp_bilinear_hs #(
  parameter int FRAC_W   = 6,
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int USER_W   = 1,
  parameter int ROUND    = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_nn,
  input  logic [FRAC_W-1:0]            dx,
  input  logic [FRAC_W-1:0]            dy,
  input  logic [CHANNELS*PIX_W-1:0]    lu,
  input  logic [CHANNELS*PIX_W-1:0]    ru,
  input  logic [CHANNELS*PIX_W-1:0]    ld,
  input  logic [CHANNELS*PIX_W-1:0]    rd,
  input  logic [USER_W-1:0]            in_user,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*PIX_W-1:0]    p,
  output logic [USER_W-1:0]            out_user
);

  localparam int WB = FRAC_W + 1;          // single-axis weight width
  localparam int WW = 2 * FRAC_W + 2;      // corner weight width
  localparam int PW = WW + PIX_W;          // weighted pixel width
  localparam int SW = PW + 2;              // four-term sum, never overflows
  localparam int DW = CHANNELS * PIX_W;

  localparam logic [WB-1:0] S   = WB'(1) << FRAC_W;
  localparam logic [SW-1:0] RND = (ROUND != 0) ? (SW'(1) << (2 * FRAC_W - 1)) : '0;

  logic advance;
  assign advance  = !out_valid | out_ready;
  assign in_ready = advance;

  // stage 1 registers: per-axis weights, corners, sideband
  logic              v1;
  logic [WB-1:0]     wxl1, wxr1, wyu1, wyd1;
  logic [DW-1:0]     lu1, ru1, ld1, rd1;
  logic [USER_W-1:0] u1;

  // stage 2 registers: corner weights
  logic              v2;
  logic [WW-1:0]     w_lu2, w_ru2, w_ld2, w_rd2;
  logic [DW-1:0]     lu2, ru2, ld2, rd2;
  logic [USER_W-1:0] u2;

  // stage 3 registers: weighted pixels per channel
  logic              v3;
  logic [PW-1:0]     m_lu3 [CHANNELS];
  logic [PW-1:0]     m_ru3 [CHANNELS];
  logic [PW-1:0]     m_ld3 [CHANNELS];
  logic [PW-1:0]     m_rd3 [CHANNELS];
  logic [USER_W-1:0] u3;

  logic [WB-1:0]     wxr_c, wyd_c, wxl_c, wyu_c;
  logic [DW-1:0]     p_nxt;
  logic [SW-1:0]     acc;

  // select right/down weights; nearest mode snaps to 0 or S on the fraction MSB
  always_comb begin
    wxr_c = {1'b0, dx};
    wyd_c = {1'b0, dy};
    if (in_nn) begin
      wxr_c = dx[FRAC_W-1] ? S : '0;
      wyd_c = dy[FRAC_W-1] ? S : '0;
    end
  end

  // exact complements so the four corner weights sum to 2^(2*FRAC_W)
  assign wxl_c = S - wxr_c;
  assign wyu_c = S - wyd_c;

  // per-channel sum, optional half-up rounding, drop the fraction bits
  always_comb begin
    p_nxt = '0;
    acc   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc = SW'(m_lu3[c]) + SW'(m_ru3[c]) + SW'(m_ld3[c]) + SW'(m_rd3[c]) + RND;
      p_nxt[c*PIX_W +: PIX_W] = PIX_W'(acc >> (2 * FRAC_W));
    end
  end

  // pipeline advance: every stage moves together or holds together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; wxl1 <= '0; wxr1 <= '0; wyu1 <= '0; wyd1 <= '0;
      lu1 <= '0; ru1 <= '0; ld1 <= '0; rd1 <= '0; u1 <= '0;
      v2 <= 1'b0; w_lu2 <= '0; w_ru2 <= '0; w_ld2 <= '0; w_rd2 <= '0;
      lu2 <= '0; ru2 <= '0; ld2 <= '0; rd2 <= '0; u2 <= '0;
      v3 <= 1'b0; u3 <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        m_lu3[c] <= '0; m_ru3[c] <= '0; m_ld3[c] <= '0; m_rd3[c] <= '0;
      end
      out_valid <= 1'b0; p <= '0; out_user <= '0;
    end else if (advance) begin
      v1   <= in_valid;
      wxl1 <= wxl_c; wxr1 <= wxr_c; wyu1 <= wyu_c; wyd1 <= wyd_c;
      lu1  <= lu; ru1 <= ru; ld1 <= ld; rd1 <= rd; u1 <= in_user;

      v2    <= v1;
      w_lu2 <= WW'(wxl1) * WW'(wyu1);
      w_ru2 <= WW'(wxr1) * WW'(wyu1);
      w_ld2 <= WW'(wxl1) * WW'(wyd1);
      w_rd2 <= WW'(wxr1) * WW'(wyd1);
      lu2 <= lu1; ru2 <= ru1; ld2 <= ld1; rd2 <= rd1; u2 <= u1;

      v3 <= v2;
      for (int c = 0; c < CHANNELS; c++) begin
        m_lu3[c] <= PW'(w_lu2) * PW'(lu2[c*PIX_W +: PIX_W]);
        m_ru3[c] <= PW'(w_ru2) * PW'(ru2[c*PIX_W +: PIX_W]);
        m_ld3[c] <= PW'(w_ld2) * PW'(ld2[c*PIX_W +: PIX_W]);
        m_rd3[c] <= PW'(w_rd2) * PW'(rd2[c*PIX_W +: PIX_W]);
      end
      u3 <= u2;

      out_valid <= v3;
      p         <= p_nxt;
      out_user  <= u3;
    end
  end

endmodule
